// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master engine among NREQ requesters.
// Define I2C_ARB_TIMEOUT_EN to abort transactions the master never completes.
module i2c_txn_arbiter #(
    parameter int NREQ        = 4,
    parameter int PTR_W       = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [NREQ-1:0]     req_rw,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [7:0]          rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic                mst_newd,
    output logic [6:0]          mst_addr,
    output logic                mst_op,
    output logic [7:0]          mst_din,
    input  logic                mst_busy,
    input  logic                mst_done,
    input  logic                mst_ack_err,
    input  logic [7:0]          mst_dout,
    output logic                arb_busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

    state_t            state;
    state_t            nxt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  pick;
    logic [PTR_W:0]    sum;
    logic [2*NREQ-1:0] req_rot;
    logic [6:0]        sel_addr;
    logic              sel_rw;
    logic [7:0]        sel_wdata;
    logic [NREQ-1:0]   gnt_q;
    logic              cap_done;
    logic              cap_tmo;
    logic              tmo;

    // Rotate so bit 0 is the pointer slot; the lowest set bit wins.
    always_comb begin
        req_rot = {req, req} >> ptr;
        sum     = '0;
        pick    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sum = {1'b0, ptr} + (PTR_W+1)'(i);
                if (sum >= NREQ_W) begin
                    sum = sum - NREQ_W;
                end
                pick = sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick == PTR_W'(j)) begin
                sel_addr  = req_addr[7*j +: 7];
                sel_rw    = req_rw[j];
                sel_wdata = req_wdata[8*j +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        cap_done = 1'b0;
        cap_tmo  = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    nxt = ISSUE;
                end
            end
            ISSUE: nxt = WAIT_BUSY;
            WAIT_BUSY, WAIT_DONE: begin
                if (mst_done) begin
                    nxt      = RESP;
                    cap_done = 1'b1;
                end else if (tmo) begin
                    nxt     = RESP;
                    cap_tmo = 1'b1;
                end else if (state == WAIT_BUSY && mst_busy) begin
                    nxt = WAIT_DONE;
                end
            end
            RESP: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= '0;
            win       <= '0;
            ptr       <= '0;
            mst_addr  <= '0;
            mst_op    <= 1'b0;
            mst_din   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= '0;
        end else begin
            if (state == IDLE && |req) begin
                gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                win      <= pick;
                mst_addr <= sel_addr;
                mst_op   <= sel_rw;
                mst_din  <= sel_wdata;
            end
            if (state == ISSUE) begin
                ptr <= (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
            end
            if (cap_done) begin
                rsp_rdata <= mst_op ? mst_dout : 8'h00;
                rsp_err   <= {1'b0, mst_ack_err};
            end
            if (cap_tmo) begin
                rsp_rdata <= 8'h00;
                rsp_err   <= 2'b10;
            end
            if (state == RESP) begin
                gnt_q <= '0;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if ((state == WAIT_BUSY || state == WAIT_DONE) && !tmo) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tmo = (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    // Without the watchdog the arbiter waits on the master indefinitely.
    assign tmo = (TIMEOUT_CYC < 0);
`endif

    assign gnt       = gnt_q;
    assign rsp_valid = (state == RESP) ? gnt_q : '0;
    assign mst_newd  = (state == ISSUE);
    assign arb_busy  = (state != IDLE);

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: transaction-level model compared every cycle,
// directed cases from the test plan, then randomized traffic.
module tb_i2c_txn_arbiter;

    localparam int N  = 4;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [7*N-1:0] req_addr = '0;
    logic [N-1:0]   req_rw = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_rdata;
    logic [1:0]     rsp_err;
    logic           mst_newd;
    logic [6:0]     mst_addr;
    logic           mst_op;
    logic [7:0]     mst_din;
    logic           mst_busy = 1'b0;
    logic           mst_done = 1'b0;
    logic           mst_ack_err = 1'b0;
    logic [7:0]     mst_dout = '0;
    logic           arb_busy;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.NREQ(N), .PTR_W(2), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .req_rw(req_rw), .req_wdata(req_wdata), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mst_newd(mst_newd), .mst_addr(mst_addr), .mst_op(mst_op),
        .mst_din(mst_din), .mst_busy(mst_busy), .mst_done(mst_done),
        .mst_ack_err(mst_ack_err), .mst_dout(mst_dout), .arb_busy(arb_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Transaction-level model: who owns the engine and what it reported.
    int         m_owner = -1;
    int         m_ptr = 0;
    int         m_t = 0;
    int         m_c;
    bit         m_issue = 1'b0;
    bit         m_resp = 1'b0;
    bit         m_ready = 1'b0;
    logic [6:0] m_addr = '0;
    logic       m_op = 1'b0;
    logic [7:0] m_din = '0;
    logic [7:0] m_rdata = '0;
    logic [1:0] m_err = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_t = 0;
            m_issue = 1'b0; m_resp = 1'b0; m_ready = 1'b1;
            m_addr = '0; m_op = 1'b0; m_din = '0; m_rdata = '0; m_err = '0;
        end else if (m_resp) begin
            m_resp  = 1'b0;
            m_owner = -1;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                m_c = (m_ptr + k) % N;
                if (req[m_c]) begin
                    m_owner = m_c;
                    break;
                end
            end
            if (m_owner >= 0) begin
                m_issue = 1'b1;
                m_addr  = req_addr[7*m_owner +: 7];
                m_op    = req_rw[m_owner];
                m_din   = req_wdata[8*m_owner +: 8];
            end
        end else if (m_issue) begin
            m_issue = 1'b0;
            m_ptr   = (m_owner + 1) % N;
            m_t     = 0;
        end else begin
            if (mst_done) begin
                m_resp  = 1'b1;
                m_rdata = m_op ? mst_dout : 8'h00;
                m_err   = {1'b0, mst_ack_err};
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (m_t == TO - 1) begin
                m_resp  = 1'b1;
                m_rdata = 8'h00;
                m_err   = 2'b10;
            end
`endif
            m_t++;
        end
    end

    int       grant_log[$];
    logic [N-1:0] prev_gnt = '0;
    logic [N-1:0] exp_gnt;

    always @(negedge clk) begin
        if (m_ready) begin
            exp_gnt = (m_owner >= 0) ? N'(1) << m_owner : '0;
            chk("gnt", gnt, exp_gnt);
            chk("rsp_valid", rsp_valid, m_resp ? exp_gnt : '0);
            chk("mst_newd", mst_newd, m_issue);
            chk("arb_busy", arb_busy, m_owner >= 0);
            chk("mst_addr", mst_addr, m_addr);
            chk("mst_op", mst_op, m_op);
            chk("mst_din", mst_din, m_din);
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_err);
            if (gnt != '0 && prev_gnt == '0) begin
                for (int k = 0; k < N; k++) begin
                    if (gnt[k]) grant_log.push_back(k);
                end
            end
            prev_gnt = gnt;
        end
    end

    // Requesters and master-engine stub, all driven from the main process.
    bit         rand_en = 1'b0;
    logic [N-1:0] rereq = '0;
    int         rsp_cnt[N];
    int         rsp_total = 0;
    int         sb_phase = 0;
    int         sb_cnt = 0;
    int         sb_lat = 2;
    bit         sb_hold = 1'b0;
    bit         sb_nobusy = 1'b0;
    bit         sb_stray = 1'b0;
    bit         sb_stray_pend = 1'b0;
    logic [7:0] sb_dout = '0;
    bit         sb_ack = 1'b0;

    task automatic new_fields(input int i);
        req_addr[7*i +: 7]  = 7'($urandom);
        req_rw[i]           = 1'($urandom);
        req_wdata[8*i +: 8] = 8'($urandom);
    endtask

    task automatic set_req(input int i, input logic [6:0] a,
                           input logic rw, input logic [7:0] d);
        req_addr[7*i +: 7]  = a;
        req_rw[i]           = rw;
        req_wdata[8*i +: 8] = d;
        req[i]              = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i]) begin
                rsp_cnt[i]++;
                rsp_total++;
                if (rereq[i]) new_fields(i);
                else req[i] = 1'b0;
            end else if (!req[i] && rand_en && $urandom_range(0, 3) == 0) begin
                new_fields(i);
                req[i] = 1'b1;
            end
        end
        mst_done = 1'b0;
        if (sb_stray_pend) begin
            mst_done      = 1'b1;
            sb_stray_pend = 1'b0;
        end
        case (sb_phase)
            0: if (mst_newd) begin
                if (rand_en) begin
                    sb_cnt    = $urandom_range(1, 3);
                    sb_lat    = $urandom_range(0, 4);
                    sb_nobusy = ($urandom_range(0, 4) == 0);
                    sb_dout   = 8'($urandom);
                    sb_ack    = ($urandom_range(0, 3) == 0);
                    sb_stray  = ($urandom_range(0, 3) == 0);
                end else begin
                    sb_cnt = 1; sb_lat = 2; sb_nobusy = 1'b0; sb_stray = 1'b0;
                end
                sb_phase = 1;
            end
            1: begin
                sb_cnt--;
                if (sb_cnt == 0) begin
                    mst_busy = !sb_nobusy;
                    sb_phase = 2;
                    sb_cnt   = sb_lat;
                end
            end
            2: if (sb_cnt == 0) begin
                if (!sb_hold) begin
                    mst_done      = 1'b1;
                    mst_dout      = sb_dout;
                    mst_ack_err   = sb_ack;
                    sb_stray_pend = sb_stray;
                end
                mst_busy = 1'b0;
                sb_phase = 0;
            end else begin
                sb_cnt--;
            end
            default: sb_phase = 0;
        endcase
    endtask

    task automatic wait_rsp(input string name, output logic [N-1:0] v,
                            output int newd);
        v = '0;
        newd = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (mst_newd) newd++;
            if (rsp_valid != '0) begin
                v = rsp_valid;
                return;
            end
        end
        expired(name);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 1000; c++) begin
            if (req == '0 && !arb_busy) return;
            step();
        end
        expired(name);
    endtask

    logic [N-1:0] v;
    int           nd;
    int           n;
    int           exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        repeat (3) step();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_newd", mst_newd, 1'b0);
        chk("rst_arb_busy", arb_busy, 1'b0);
        rst = 1'b0;

        // Fairness: all four hold requests and re-request after each response.
        for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
        rsp_total = 0;
        grant_log.delete();
        rereq = '1;
        for (int i = 0; i < N; i++) new_fields(i);
        req = '1;
        for (int c = 0; c < 400 && rsp_total < 4; c++) step();
        if (rsp_total < 4) expired("fair_round");
        for (int i = 0; i < N; i++) chk("fair_rsp_per_round", rsp_cnt[i], 1);
        for (int c = 0; c < 400 && grant_log.size() < 5; c++) step();
        if (grant_log.size() < 5) expired("fair_order");
        else for (int i = 0; i < 5; i++) chk("fair_order", grant_log[i], exp_order[i]);
        rereq = '0;
        drain("fair_drain");
        step();

        // Single write on requester 0.
        sb_dout = 8'hEE;
        sb_ack  = 1'b0;
        set_req(0, 7'h50, 1'b0, 8'hA5);
        step();
        chk("wr_gnt", gnt, 4'b0001);
        chk("wr_newd", mst_newd, 1'b1);
        chk("wr_addr", mst_addr, 7'h50);
        chk("wr_din", mst_din, 8'hA5);
        wait_rsp("wr_rsp", v, nd);
        chk("wr_extra_newd", nd, 0);
        chk("wr_rsp_valid", v, 4'b0001);
        chk("wr_err", rsp_err, 2'b00);
        chk("wr_rdata", rsp_rdata, 8'h00);
        step();

        // Single read on requester 2.
        sb_dout = 8'h3C;
        set_req(2, 7'h21, 1'b1, 8'h00);
        step();
        chk("rd_gnt", gnt, 4'b0100);
        wait_rsp("rd_rsp", v, nd);
        chk("rd_rsp_valid", v, 4'b0100);
        chk("rd_rdata", rsp_rdata, 8'h3C);
        chk("rd_err", rsp_err, 2'b00);
        step();

        // NACK on requester 1, then a clean read on requester 3.
        sb_dout = 8'h77;
        sb_ack  = 1'b1;
        set_req(1, 7'h13, 1'b1, 8'h00);
        wait_rsp("nack_rsp", v, nd);
        chk("nack_rsp_valid", v, 4'b0010);
        chk("nack_err", rsp_err, 2'b01);
        chk("nack_rdata", rsp_rdata, 8'h77);
        step();
        sb_ack  = 1'b0;
        sb_dout = 8'h5A;
        set_req(3, 7'h44, 1'b1, 8'h00);
        wait_rsp("after_nack_rsp", v, nd);
        chk("after_nack_valid", v, 4'b1000);
        chk("after_nack_rdata", rsp_rdata, 8'h5A);
        chk("after_nack_err", rsp_err, 2'b00);
        step();

        // Reset while the master is mid-transfer.
        sb_hold = 1'b1;
        set_req(0, 7'h2A, 1'b0, 8'h11);
        n = 0;
        while (n < 20 && !mst_busy) begin
            step();
            n++;
        end
        if (!mst_busy) expired("rst_mid_busy");
        step();
        step();
        chk("rst_mid_busy_state", arb_busy, 1'b1);
        req = '0;
        rst = 1'b1;
        step();
        chk("rst_mid_gnt", gnt, 4'b0000);
        chk("rst_mid_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_mid_addr", mst_addr, 7'h00);
        chk("rst_mid_rdata", rsp_rdata, 8'h00);
        chk("rst_mid_arb_busy", arb_busy, 1'b0);
        rst      = 1'b0;
        sb_hold  = 1'b0;
        sb_phase = 0;
        mst_busy = 1'b0;
        set_req(1, 7'h31, 1'b0, 8'h22);
        set_req(3, 7'h33, 1'b0, 8'h44);
        step();
        chk("rst_ptr_gnt", gnt, 4'b0010);
        wait_rsp("rst_rsp1", v, nd);
        chk("rst_rsp1_valid", v, 4'b0010);
        wait_rsp("rst_rsp3", v, nd);
        chk("rst_rsp3_valid", v, 4'b1000);
        step();

`ifdef I2C_ARB_TIMEOUT_EN
        // Withheld completion: RESP lands TO edges after the edge leaving ISSUE,
        // i.e. TO+1 steps after the step that observes mst_newd.
        sb_hold = 1'b1;
        set_req(0, 7'h0F, 1'b1, 8'h00);
        n = 0;
        while (n < 10 && !mst_newd) begin
            step();
            n++;
        end
        if (!mst_newd) expired("to_newd");
        n = 0;
        while (n < 200 && rsp_valid == '0) begin
            step();
            n++;
        end
        chk("to_latency", n, TO + 1);
        chk("to_rsp_valid", rsp_valid, 4'b0001);
        chk("to_err", rsp_err, 2'b10);
        chk("to_rdata", rsp_rdata, 8'h00);
        step();
        sb_hold       = 1'b0;
        sb_stray_pend = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("to_stray_done", rsp_valid, 4'b0000);
        end
`endif

        // Randomized traffic against the model.
        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        drain("rand_drain");
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
